mem_req_queue_mp: RTL and testbench

Parametrised multi-port memory request queue between the load/store issue ports and the data-cache/bus interface.
- Circular buffer of QDEP entries; accepts up to NPORTS requests per cycle in port order.
- Issues entries in FIFO order.
- Forwards store data to loads fully covered by a queued store.
- Filters replayed requests by transaction id.

---
 rtl/mem_req_queue_mp_if.sv | 48 ++++
 rtl/mem_req_queue_mp.sv | 182 ++++++++++++++++++
 tb/tb_mem_req_queue_mp.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mem_req_queue_mp_if.sv
// mem_req_queue_mp_if: request-queue constants and issue/cache-side bus interface
package mem_req_queue_mp_pkg;
  localparam logic [3:0] MR_LOAD = 4'h1;
  localparam logic [3:0] MR_LOADZ = 4'h2;
  localparam logic [3:0] MR_STORE = 4'h3;
  localparam logic [2:0] SZ_BYT = 3'd0;
  localparam logic [2:0] SZ_WYDE = 3'd1;
  localparam logic [2:0] SZ_TETRA = 3'd2;
  localparam logic [2:0] SZ_OCTA = 3'd3;
  localparam logic [2:0] SZ_HEXI = 3'd4;
endpackage

interface mem_req_queue_mp_if #(
  parameter int AWID = 32,
  parameter int DWID = 128,
  parameter int QDEP = 16,
  parameter int NPORTS = 2,
  parameter int TIDW = 8
);
  logic [NPORTS-1:0] wr;
  logic [NPORTS-1:0] wr_ack;
  logic [NPORTS*4-1:0] i_func;
  logic [NPORTS*3-1:0] i_sz;
  logic [NPORTS*AWID-1:0] i_adr;
  logic [NPORTS*DWID-1:0] i_dat;
  logic [NPORTS*TIDW-1:0] i_tid;
  logic rd;
  logic [3:0] o_func;
  logic [2:0] o_sz;
  logic [AWID-1:0] o_adr;
  logic [DWID-1:0] o_dat;
  logic [TIDW-1:0] o_tid;
  logic [15:0] o_sel;
  logic valid;
  logic empty;
  logic full;
  logic [$clog2(QDEP):0] count;
  logic [NPORTS*DWID-1:0] ld_dat;
  logic [NPORTS-1:0] found;
  modport master (
    output wr, i_func, i_sz, i_adr, i_dat, i_tid, rd,
    input wr_ack, o_func, o_sz, o_adr, o_dat, o_tid, o_sel, valid, empty, full, count, ld_dat, found
  );
  modport slave (
    input wr, i_func, i_sz, i_adr, i_dat, i_tid, rd,
    output wr_ack, o_func, o_sz, o_adr, o_dat, o_tid, o_sel, valid, empty, full, count, ld_dat, found
  );
endinterface

// File: rtl/mem_req_queue_mp.sv
// mem_req_queue_mp: multi-port FIFO request queue with store-to-load forwarding and tid replay filter.
// Define MEMQ_STORE_MERGE_EN to merge port-0 stores into the youngest queued store of the same line.
module mem_req_queue_mp
  import mem_req_queue_mp_pkg::*;
#(
  parameter int AWID = 32,
  parameter int DWID = 128,
  parameter int QDEP = 16,
  parameter int NPORTS = 2,
  parameter int TIDW = 8
) (
  input logic clk,
  input logic rst,
  mem_req_queue_mp_if.slave bus
);
  localparam int PW = $clog2(QDEP);
  localparam int CW = PW + 1;

  function automatic logic [15:0] fn_sel(input logic [2:0] sz);
    return sz == SZ_BYT ? 16'h0001 : sz == SZ_WYDE ? 16'h0003 : sz == SZ_TETRA ? 16'h000F :
           sz == SZ_HEXI ? 16'hFFFF : 16'h00FF;
  endfunction

  function automatic logic [3:0] fn_top(input logic [2:0] sz);
    return sz == SZ_BYT ? 4'd0 : sz == SZ_WYDE ? 4'd1 : sz == SZ_TETRA ? 4'd3 :
           sz == SZ_HEXI ? 4'd15 : 4'd7;
  endfunction

  function automatic logic [DWID-1:0] fn_bmask(input logic [15:0] s);
    fn_bmask = '0;
    for (int b = 0; b < 16; b++) fn_bmask[b*8 +: 8] = {8{s[b]}};
  endfunction

  // entry data is held line-aligned: byte b of the line sits at bits b*8
  logic [3:0] r_func [QDEP];
  logic [2:0] r_sz [QDEP];
  logic [AWID-1:0] r_adr [QDEP];
  logic [DWID-1:0] r_dat [QDEP];
  logic [TIDW-1:0] r_tid [QDEP];
  logic [15:0] r_sel [QDEP];
  logic [QDEP-1:0] r_v;
  logic [PW-1:0] r_head, r_tail;
  logic [CW-1:0] r_count;
  logic [NPORTS-1:0] r_ack;
  logic [TIDW-1:0] r_last_tid;

  logic [3:0] w_func [NPORTS];
  logic [2:0] w_sz [NPORTS];
  logic [AWID-1:0] w_adr [NPORTS];
  logic [DWID-1:0] w_abs [NPORTS];
  logic [TIDW-1:0] w_tid [NPORTS];
  logic [15:0] w_sel [NPORTS];
  logic [PW-1:0] w_hidx [NPORTS];
  logic [PW-1:0] w_slot [NPORTS];
  logic [PW-1:0] w_ord [QDEP];
  logic [NPORTS-1:0] w_ld, w_found, w_acc, w_enq;
  logic [CW-1:0] w_k, w_free;
  logic [TIDW-1:0] w_lt;
  logic [PW-1:0] w_yidx;
  logic w_pop, w_merge, w_can_merge;

  assign w_pop = bus.rd && r_v[r_head];
  assign w_free = CW'(QDEP) - r_count;
  assign w_yidx = r_tail - PW'(1);

  genvar g;
  generate
    for (g = 0; g < NPORTS; g++) begin : g_port
      logic [DWID-1:0] w_raw, w_m;
      logic w_sgn;
      assign w_func[g] = bus.i_func[g*4 +: 4];
      assign w_sz[g] = bus.i_sz[g*3 +: 3];
      assign w_adr[g] = bus.i_adr[g*AWID +: AWID];
      assign w_tid[g] = bus.i_tid[g*TIDW +: TIDW];
      assign w_abs[g] = bus.i_dat[g*DWID +: DWID] << {w_adr[g][3:0], 3'b000};
      assign w_sel[g] = fn_sel(w_sz[g]) << w_adr[g][3:0];
      assign w_ld[g] = w_func[g] == MR_LOAD || w_func[g] == MR_LOADZ;
      assign w_raw = r_dat[w_hidx[g]] >> {w_adr[g][3:0], 3'b000};
      assign w_m = fn_bmask(fn_sel(w_sz[g]));
      assign w_sgn = w_func[g] == MR_LOAD && w_raw[{fn_top(w_sz[g]), 3'b111}];
      assign bus.ld_dat[g*DWID +: DWID] = w_found[g] ? (w_raw & w_m) | (w_sgn ? ~w_m : '0) : '0;
    end
  endgenerate

  always_comb
    for (int j = 0; j < QDEP; j++) w_ord[j] = r_head + PW'(j);

  // scan oldest to youngest so the last hit is the youngest covering store
  always_comb
    for (int p = 0; p < NPORTS; p++) begin
      w_found[p] = 1'b0;
      w_hidx[p] = '0;
      for (int j = 0; j < QDEP; j++)
        if (w_ld[p] && r_v[w_ord[j]] && r_func[w_ord[j]] == MR_STORE &&
            r_adr[w_ord[j]][AWID-1:4] == w_adr[p][AWID-1:4] &&
            (r_sel[w_ord[j]] & w_sel[p]) == w_sel[p]) begin
          w_found[p] = 1'b1;
          w_hidx[p] = w_ord[j];
        end
    end

`ifdef MEMQ_STORE_MERGE_EN
  // count>1 keeps the youngest entry off the head, so it can never be the one popping
  assign w_can_merge = w_func[0] == MR_STORE && r_count > CW'(1) && r_func[w_yidx] == MR_STORE &&
                       r_adr[w_yidx][AWID-1:4] == w_adr[0][AWID-1:4];
`else
  assign w_can_merge = 1'b0;
`endif

  always_comb begin
    w_k = '0;
    w_lt = r_last_tid;
    w_acc = '0;
    w_enq = '0;
    w_merge = 1'b0;
    for (int p = 0; p < NPORTS; p++) begin
      w_slot[p] = r_tail + w_k[PW-1:0];
      if (bus.wr[p]) begin
        if ((w_ld[p] && w_found[p]) || w_tid[p] == w_lt) w_acc[p] = 1'b1;
        else if (p == 0 && w_can_merge) begin
          w_acc[p] = 1'b1;
          w_merge = 1'b1;
          w_lt = w_tid[p];
        end else if (w_k < w_free) begin
          w_acc[p] = 1'b1;
          w_enq[p] = 1'b1;
          w_k = w_k + CW'(1);
          w_lt = w_tid[p];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
      r_count <= '0;
      r_v <= '0;
      r_ack <= '0;
      r_last_tid <= '1;
    end else begin
      r_ack <= w_acc;
      r_last_tid <= w_lt;
      r_head <= r_head + PW'(w_pop);
      r_tail <= r_tail + w_k[PW-1:0];
      r_count <= r_count + w_k - CW'(w_pop);
      if (w_pop) r_v[r_head] <= 1'b0;
      for (int p = 0; p < NPORTS; p++)
        if (w_enq[p]) r_v[w_slot[p]] <= 1'b1;
    end

  always_ff @(posedge clk) begin
    for (int p = 0; p < NPORTS; p++)
      if (w_enq[p]) begin
        r_func[w_slot[p]] <= w_func[p];
        r_sz[w_slot[p]] <= w_sz[p];
        r_adr[w_slot[p]] <= w_adr[p];
        r_dat[w_slot[p]] <= w_abs[p];
        r_tid[w_slot[p]] <= w_tid[p];
        r_sel[w_slot[p]] <= w_sel[p];
      end
    if (w_merge) begin
      r_sel[w_yidx] <= r_sel[w_yidx] | w_sel[0];
      r_dat[w_yidx] <= (r_dat[w_yidx] & ~fn_bmask(w_sel[0])) | (w_abs[0] & fn_bmask(w_sel[0]));
      if (w_adr[0][3:0] < r_adr[w_yidx][3:0]) r_adr[w_yidx][3:0] <= w_adr[0][3:0];
    end
  end

  assign bus.wr_ack = r_ack;
  assign bus.found = w_found;
  assign bus.o_func = r_func[r_head];
  assign bus.o_sz = r_sz[r_head];
  assign bus.o_adr = r_adr[r_head];
  assign bus.o_dat = r_dat[r_head] >> {r_adr[r_head][3:0], 3'b000};
  assign bus.o_tid = r_tid[r_head];
  assign bus.o_sel = r_sel[r_head];
  assign bus.valid = r_v[r_head];
  assign bus.empty = r_count == '0;
  assign bus.full = r_count == CW'(QDEP);
  assign bus.count = r_count;
endmodule

// File: tb/tb_mem_req_queue_mp.sv
// tb_mem_req_queue_mp: directed checks of forwarding, replay filter, full/pop and async reset
module tb_mem_req_queue_mp;
  import mem_req_queue_mp_pkg::*;
  localparam int AWID = 32, DWID = 128, QDEP = 16, NPORTS = 2, TIDW = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_run = 0;
  int n_fail = 0;

  mem_req_queue_mp_if #(.AWID(AWID), .DWID(DWID), .QDEP(QDEP), .NPORTS(NPORTS), .TIDW(TIDW)) bus ();
  mem_req_queue_mp #(.AWID(AWID), .DWID(DWID), .QDEP(QDEP), .NPORTS(NPORTS), .TIDW(TIDW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DWID-1:0] got, input logic [DWID-1:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int p, input logic [3:0] f, input logic [2:0] s, input logic [31:0] a,
                     input logic [127:0] d, input logic [7:0] t);
    bus.i_func[p*4 +: 4] = f;
    bus.i_sz[p*3 +: 3] = s;
    bus.i_adr[p*AWID +: AWID] = a;
    bus.i_dat[p*DWID +: DWID] = d;
    bus.i_tid[p*TIDW +: TIDW] = t;
  endtask

  initial begin
    bus.wr = '0;
    bus.rd = 1'b0;
    bus.i_func = '0;
    bus.i_sz = '0;
    bus.i_adr = '0;
    bus.i_dat = '0;
    bus.i_tid = '0;
    step;
    step;
    rst = 1'b0;
    chk("rst_count", bus.count, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_valid", bus.valid, 0);
    chk("rst_ack", bus.wr_ack, 0);
    // store octa then byte loads covered by it
    req(0, MR_STORE, SZ_OCTA, 32'h1008, 128'h1122334455667788, 8'h01);
    bus.wr = 2'b01;
    step;
    bus.wr = 2'b00;
    chk("st_ack", bus.wr_ack, 2'b01);
    chk("st_count", bus.count, 1);
    chk("st_osel", bus.o_sel, 16'hFF00);
    chk("st_odat", bus.o_dat, 128'h1122334455667788);
    req(1, MR_LOAD, SZ_BYT, 32'h100F, 0, 8'h02);
    #1;
    chk("fw_found_f", bus.found, 2'b10);
    chk("fw_ld_f", bus.ld_dat[2*DWID-1:DWID], 128'h11);
    req(1, MR_LOADZ, SZ_BYT, 32'h100F, 0, 8'h02);
    #1;
    chk("fw_ldz_f", bus.ld_dat[2*DWID-1:DWID], 128'h11);
    req(1, MR_LOAD, SZ_BYT, 32'h1008, 0, 8'h02);
    #1;
    chk("fw_ld_sext", bus.ld_dat[2*DWID-1:DWID], 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFF88);
    req(1, MR_LOADZ, SZ_BYT, 32'h1008, 0, 8'h02);
    #1;
    chk("fw_ldz_88", bus.ld_dat[2*DWID-1:DWID], 128'h88);
    bus.wr = 2'b10;
    step;
    bus.wr = 2'b00;
    chk("fw_ack", bus.wr_ack, 2'b10);
    chk("fw_noenq", bus.count, 1);
    // two same-address stores, youngest must win
    req(0, MR_STORE, SZ_TETRA, 32'h2000, 128'hAAAAAAAA, 8'h03);
    req(1, MR_STORE, SZ_TETRA, 32'h2000, 128'hBBBBBBBB, 8'h04);
    bus.wr = 2'b11;
    step;
    bus.wr = 2'b00;
    chk("st2_ack", bus.wr_ack, 2'b11);
    chk("st2_count", bus.count, 3);
    req(1, MR_LOADZ, SZ_BYT, 32'h9000, 0, 8'h00);
    req(0, MR_LOAD, SZ_TETRA, 32'h2000, 0, 8'h05);
    #1;
    chk("young_found", bus.found, 2'b01);
    chk("young_dat", bus.ld_dat[DWID-1:0], 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_BBBBBBBB);
    req(0, MR_LOAD, SZ_OCTA, 32'h2000, 0, 8'h05);
    #1;
    chk("part_found", bus.found, 2'b00);
    chk("part_dat", bus.ld_dat[DWID-1:0], 0);
    bus.wr = 2'b01;
    step;
    bus.wr = 2'b00;
    chk("part_ack", bus.wr_ack, 2'b01);
    chk("part_enq", bus.count, 4);
    // replay filter: same tid on both ports, then again next cycle
    req(0, MR_STORE, SZ_BYT, 32'h4000, 128'h5A, 8'h42);
    req(1, MR_STORE, SZ_BYT, 32'h4000, 128'h5A, 8'h42);
    bus.wr = 2'b11;
    step;
    chk("tid_ack0", bus.wr_ack, 2'b11);
    chk("tid_cnt0", bus.count, 5);
    bus.wr = 2'b01;
    step;
    bus.wr = 2'b00;
    chk("tid_ack1", bus.wr_ack, 2'b01);
    chk("tid_cnt1", bus.count, 5);
    // fill to 15 with distinct lines and tids
    for (int i = 0; i < 5; i++) begin
      req(0, MR_STORE, SZ_BYT, 32'h5000 + 32'(2*i) * 32'h10, 128'h1, 8'(8'h10 + 2*i));
      req(1, MR_STORE, SZ_BYT, 32'h5000 + 32'(2*i+1) * 32'h10, 128'h2, 8'(8'h11 + 2*i));
      bus.wr = 2'b11;
      step;
    end
    chk("fill_count", bus.count, 15);
    req(0, MR_STORE, SZ_BYT, 32'h6000, 128'h3, 8'h20);
    req(1, MR_STORE, SZ_BYT, 32'h6010, 128'h4, 8'h21);
    step;
    chk("full_ack", bus.wr_ack, 2'b01);
    chk("full_count", bus.count, 16);
    chk("full_flag", bus.full, 1);
    bus.wr = 2'b10;
    bus.rd = 1'b1;
    step;
    bus.rd = 1'b0;
    chk("rdfull_ack", bus.wr_ack, 2'b00);
    chk("rdfull_count", bus.count, 15);
    chk("rdfull_flag", bus.full, 0);
    chk("head_adr", bus.o_adr, 32'h2000);
    chk("head_dat", bus.o_dat, 128'hAAAAAAAA);
    chk("head_sel", bus.o_sel, 16'h000F);
    chk("head_tid", bus.o_tid, 8'h03);
    step;
    chk("held_ack", bus.wr_ack, 2'b10);
    chk("held_count", bus.count, 16);
    // asynchronous reset mid-stream
    bus.wr = 2'b01;
    req(0, MR_STORE, SZ_BYT, 32'h7000, 128'h9, 8'h50);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_count", bus.count, 0);
    chk("arst_empty", bus.empty, 1);
    chk("arst_valid", bus.valid, 0);
    chk("arst_ack", bus.wr_ack, 0);
    bus.wr = 2'b00;
    step;
    rst = 1'b0;
    req(0, MR_LOAD, SZ_TETRA, 32'h2000, 0, 8'h51);
    #1;
    chk("arst_found", bus.found, 0);
    chk("arst_lddat", bus.ld_dat, 0);
    // last_tid resets to all-ones; rd while empty is ignored
    req(0, MR_STORE, SZ_BYT, 32'h7000, 128'h9, 8'hFF);
    bus.wr = 2'b01;
    bus.rd = 1'b1;
    step;
    bus.rd = 1'b0;
    chk("ff_ack", bus.wr_ack, 2'b01);
    chk("ff_count", bus.count, 0);
    // byte stores to one line behind a different head entry
    req(0, MR_STORE, SZ_BYT, 32'h6000, 128'h77, 8'h30);
    step;
    req(0, MR_STORE, SZ_BYT, 32'h3000, 128'h01, 8'h31);
    step;
    chk("mg_cnt0", bus.count, 2);
    req(0, MR_STORE, SZ_BYT, 32'h3001, 128'h02, 8'h32);
    step;
    bus.wr = 2'b00;
    chk("mg_ack", bus.wr_ack, 2'b01);
    bus.rd = 1'b1;
    step;
    bus.rd = 1'b0;
    chk("mg_adr", bus.o_adr, 32'h3000);
`ifdef MEMQ_STORE_MERGE_EN
    chk("mg_count", bus.count, 1);
    chk("mg_sel", bus.o_sel, 16'h0003);
    chk("mg_dat", bus.o_dat[15:0], 16'h0201);
`else
    chk("mg_count", bus.count, 2);
    chk("mg_sel", bus.o_sel, 16'h0001);
    chk("mg_dat", bus.o_dat[15:0], 16'h0001);
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
